hilo_unit: RTL and testbench
============================

# hilo_unit

Multiply/divide sequencer and HI/LO register pair for the 54-instruction CPU. Sits directly downstream of the unsigned multiplier (MULTU), the signed multiplier (MULT) and the divider. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the decode stage, pulses the matching unit's enable, waits out its latency, and captures the 64-bit product or the quotient/remainder into HI/LO. It stalls the pipeline whenever a HI/LO-related op arrives while a result is still outstanding.

## Interface
Parameters:
- MUL_LAT, 1, cycles from the `mul_ena` cycle to the last cycle before capture; the product is captured on the clock edge ending cycle N+MUL_LAT. Legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- op_valid  in  1  decode presents a HI/LO op this cycle.
- op  in  3  operation code from `md_pkg`.
- rs_val  in  32  source for MTHI/MTLO.
- rt_val  in  32  divisor; used only for the divide-by-zero check.
- mul_ena  out  1  one-cycle enable to the multipliers; the multiplier samples its operands on this edge.
- mul_signed  out  1  0 selects MULTU, 1 selects MULT; valid while `mul_ena` is high.
- mul_z  in  64  selected product, registered by the multiplier.
- div_start  out  1  one-cycle start pulse to the divider.
- div_signed  out  1  0 selects DIVU, 1 selects DIV.
- div_done  in  1  one-cycle pulse; `div_q` and `div_r` are valid in that cycle.
- div_q, div_r  in  32 each  quotient and remainder.
- stall  out  1  hold the decode stage; the op must be re-presented.
- rd_data  out  32  MFHI/MFLO result (combinational).
- hi, lo  out  32 each  architectural HI and LO.
- busy  out  1  asserted when the state is not IDLE.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT.
- Reset values (asynchronous): state=IDLE, cnt=0, hi=0, lo=0. All outputs are 0, including `stall`, `mul_ena`, `div_start`, `rd_data` and `busy`.

IDLE with op_valid=1:
- MULTU/MULT
  - `mul_ena`=1 and `mul_signed`=op[0] in this cycle.
  - Next state is MUL_WAIT with cnt=MUL_LAT.
- DIVU/DIV with rt_val≠0
  - `div_start`=1 and `div_signed`=op[0].
  - Next state is DIV_WAIT.
- DIVU/DIV with rt_val=0
  - No start pulse is issued and HI/LO are unchanged (team-defined behaviour).
  - State stays IDLE and there is no stall.
- MTHI/MTLO: hi (or lo) is written with rs_val at the clock edge. No stall.
- MFHI/MFLO: rd_data = hi (or lo) in the same cycle. No stall.

MUL_WAIT:
- cnt decrements each cycle.
- In the cycle where cnt==1: at the clock edge, hi ← mul_z[63:32], lo ← mul_z[31:0], and next state is IDLE.

DIV_WAIT:
- In the div_done cycle: at the clock edge, hi ← div_r, lo ← div_q, and next state is IDLE.
- There is no timeout.

Stall and busy:
- stall = op_valid & (state≠IDLE). This is combinational and covers all eight ops, including MTHI/MTLO (write-after-write ordering).
- A stalled op has no side effects.
- Outputs `mul_ena`, `div_start`, `rd_data` and the HI/LO writes are all gated by state==IDLE.
- rd_data is 0 unless IDLE & op_valid & op∈{MFHI,MFLO}.
- Non-HI/LO instructions never assert op_valid, so they are never stalled by this block.

Boundary conditions:
- Capture cycle: state is still non-IDLE, so a new op in that cycle stalls. It is accepted in the following cycle and sees the new HI/LO.
- div_done while in IDLE or MUL_WAIT is ignored.
- mul_z changes outside the capture cycle are ignored.
- Reset mid-operation: returns to IDLE at once and clears HI/LO. A late div_done after reset is ignored.

## Timing
- MULTU/MULT issued in cycle N:
  - mul_ena is high in N.
  - Capture happens on the edge ending N+MUL_LAT.
  - New HI/LO are visible from N+MUL_LAT+1.
  - Ops in cycles N+1..N+MUL_LAT stall.
- DIV issued in N with div_done in cycle D:
  - HI/LO are visible from D+1.
  - Ops in N+1..D stall.
- MFHI/MFLO in IDLE has zero latency.
- MTHI/MTLO take effect on the next edge; a back-to-back MFHI returns the new value.
- cnt width is 4 bits.

## Structure
- `md_pkg` holds:
  - op encodings: MULTU=0, MULT=1, DIVU=2, DIV=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7. Bit 0 of the multiply/divide codes is the signed flag.
  - the state enum: IDLE=0, MUL_WAIT=1, DIV_WAIT=2.
- Natural sub-module: `hilo_regs`, the two 32-bit registers with independent write enables, asynchronous clear and two read ports. The FSM, counter and stall logic stay in `hilo_unit`.

## Test plan
- Reset release, then MFHI and MFLO: rd_data=0 for both, stall=0.
- MULTU with a stub multiplier giving mul_z=0xFFFFFFFE_00000001 (0xFFFFFFFF²), MUL_LAT=1:
  - mul_ena high for exactly one cycle.
  - MFHI in N+1 stalls.
  - In N+2, MFHI gives 0xFFFFFFFE and MFLO gives 0x00000001.
- DIVU with rt_val=3 and a stub that returns div_done 33 cycles later with q=0x5, r=0x2:
  - stall is held through the done cycle.
  - Afterwards lo=5, hi=2.
- DIV with rt_val=0 after MTHI 0x1234 / MTLO 0x5678: no div_start, no stall, hi/lo unchanged at 0x1234/0x5678.
- MTLO 0xA5A5A5A5, then MFLO the next cycle: rd_data=0xA5A5A5A5. The same MTLO presented during MUL_WAIT stalls, and lo then takes the product value rather than 0xA5A5A5A5.
- Reset asserted two cycles into DIV_WAIT:
  - immediately state=IDLE, hi=lo=0, stall=0.
  - a div_done pulse arriving after reset leaves hi/lo at 0.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - md_op_t : 3-bit operation codes presented by decode. For the four
//               multiply/divide codes bit 0 is the signed flag.
//   - state_t : sequencer states, exposed on the debug port of hilo_unit.
//   - CNT_W   : width of the multiply latency counter.
//   - is_mul / is_div : op-class helpers.
package md_pkg;

  localparam int OP_W  = 3;
  localparam int CNT_W = 4;

  typedef enum logic [OP_W-1:0] {
    MULTU = 3'd0,
    MULT  = 3'd1,
    DIVU  = 3'd2,
    DIV   = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5,
    MFHI  = 3'd6,
    MFLO  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  // MULTU/MULT share op[2:1] == 2'b00; DIVU/DIV share op[2:1] == 2'b01.
  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op[2:1] == 2'b00);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// hilo_unit_if: bundles the decode-side op bus and the multiplier/divider
// handshake of the HI/LO sequencer.
//
// Handshake rules (all signals are sampled on the rising edge of clk):
//   - decode -> unit: op_valid/op/rs_val/rt_val describe one HI/LO op. When
//     stall is high in the same cycle the op is not taken and has no side
//     effects; decode must present it again. There is no separate ready:
//     an op is accepted exactly in a cycle with op_valid=1 and stall=0.
//   - unit -> multiplier: mul_ena is a one-cycle pulse; the multiplier
//     samples its operands on that edge, and mul_signed qualifies it.
//     mul_z is only consumed in the capture cycle.
//   - unit -> divider: div_start is a one-cycle pulse qualified by
//     div_signed; the divider answers with a one-cycle div_done pulse with
//     div_q/div_r valid in that same cycle.
//   - rd_data is a combinational MFHI/MFLO result, zero otherwise.
//
// Modports: slave = the hilo_unit itself; master = the environment
// (decode stage plus multiplier/divider).
interface hilo_unit_if;
  import md_pkg::*;

  logic            op_valid;
  logic [OP_W-1:0] op;
  logic [31:0]     rs_val;
  logic [31:0]     rt_val;
  logic            stall;
  logic [31:0]     rd_data;

  logic            mul_ena;
  logic            mul_signed;
  logic [63:0]     mul_z;

  logic            div_start;
  logic            div_signed;
  logic            div_done;
  logic [31:0]     div_q;
  logic [31:0]     div_r;

  modport slave (
    input  op_valid, op, rs_val, rt_val, mul_z, div_done, div_q, div_r,
    output stall, rd_data, mul_ena, mul_signed, div_start, div_signed
  );

  modport master (
    output op_valid, op, rs_val, rt_val, mul_z, div_done, div_q, div_r,
    input  stall, rd_data, mul_ena, mul_signed, div_start, div_signed
  );

endinterface

// File: rtl/hilo_regs.sv
// hilo_regs: the architectural HI and LO registers.
// Ports:
//   clk, reset     : clock; asynchronous active-high clear of both registers
//   hi_we, hi_d    : write enable and data for HI
//   lo_we, lo_d    : write enable and data for LO
//   hi_q, lo_q     : read ports (current register contents)
module hilo_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_we,
  input  logic [31:0] hi_d,
  input  logic        lo_we,
  input  logic [31:0] lo_d,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
    end else if (hi_we) begin
      hi_q <= hi_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q <= 32'd0;
    end else if (lo_we) begin
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: multiply/divide sequencer in front of the HI/LO register pair.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from decode, pulses the
// matching arithmetic unit, waits out its latency and captures the result
// into HI/LO. Any op arriving while a result is outstanding is stalled.
// Parameters:
//   MUL_LAT   : cycles from the mul_ena cycle to the capture cycle (1..15)
// Ports:
//   clk, reset: clock; asynchronous active-high reset
//   bus       : hilo_unit_if.slave (decode op bus + mul/div handshake)
//   hi, lo    : architectural HI and LO
//   busy      : a multiply or divide result is outstanding
//   dbg_state : current sequencer state
module hilo_unit
  import md_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  hilo_unit_if.slave  bus,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output state_t      dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic               hi_we;
  logic               lo_we;
  logic [31:0]        hi_d;
  logic [31:0]        lo_d;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  // State and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, handshake pulses and HI/LO write controls. Every side
  // effect of a decode op lives in the IDLE branch, so a stalled op cannot
  // touch anything.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bus.mul_ena    = 1'b0;
    bus.mul_signed = 1'b0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.rd_data    = 32'd0;
    hi_we          = 1'b0;
    lo_we          = 1'b0;
    hi_d           = 32'd0;
    lo_d           = 32'd0;

    case (state)
      IDLE: begin
        if (bus.op_valid) begin
          if (is_mul(bus.op)) begin
            bus.mul_ena    = 1'b1;
            bus.mul_signed = bus.op[0];
            state_nxt      = MUL_WAIT;
            cnt_nxt        = CNT_LOAD;
          end else if (is_div(bus.op)) begin
            // A zero divisor is dropped: no start, HI/LO keep their value.
            if (bus.rt_val != 32'd0) begin
              bus.div_start  = 1'b1;
              bus.div_signed = bus.op[0];
              state_nxt      = DIV_WAIT;
            end
          end else begin
            case (bus.op)
              MTHI: begin
                hi_we = 1'b1;
                hi_d  = bus.rs_val;
              end
              MTLO: begin
                lo_we = 1'b1;
                lo_d  = bus.rs_val;
              end
              MFHI:    bus.rd_data = hi_q;
              MFLO:    bus.rd_data = lo_q;
              default: ;
            endcase
          end
        end
      end

      MUL_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        // cnt==1 marks the capture cycle: the multiplier's registered
        // product is valid now and is written on the closing edge.
        if (cnt == CNT_W'(1)) begin
          hi_we     = 1'b1;
          lo_we     = 1'b1;
          hi_d      = bus.mul_z[63:32];
          lo_d      = bus.mul_z[31:0];
          state_nxt = IDLE;
        end
      end

      DIV_WAIT: begin
        if (bus.div_done) begin
          hi_we     = 1'b1;
          lo_we     = 1'b1;
          hi_d      = bus.div_r;
          lo_d      = bus.div_q;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The capture cycle is still non-IDLE, so an op there stalls and is
  // accepted one cycle later, seeing the freshly written HI/LO.
  assign bus.stall = bus.op_valid & (state != IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign hi        = hi_q;
  assign lo        = lo_q;

  hilo_regs u_regs (
    .clk   (clk),
    .reset (reset),
    .hi_we (hi_we),
    .hi_d  (hi_d),
    .lo_we (lo_we),
    .lo_d  (lo_d),
    .hi_q  (hi_q),
    .lo_q  (lo_q)
  );

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed and randomized checks of hilo_unit against a
// cycle-indexed transaction model, with stub multiplier and divider.
module tb_hilo_unit;
  import md_pkg::*;

  localparam int MUL_LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_unit_if bus ();
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  state_t      dbg_state;

  hilo_unit #(.MUL_LAT(MUL_LAT)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Returns {quotient, remainder}.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {q, r};
  endfunction

  // ---------------- model and stub state ----------------
  int          cyc = 0;
  int          next_div_lat = 10;

  // Transaction model: architectural HI/LO plus the one outstanding result
  // (capture cycle index, values, and which unit produces it).
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_pend_end = -1;
  logic [31:0] m_pend_hi;
  logic [31:0] m_pend_lo;
  state_t      m_kind = IDLE;

  // Stubs: the multiplier shows its product only in the capture cycle
  // (garbage otherwise); the divider fires done after its chosen latency
  // and emits stray done pulses while it has nothing outstanding.
  int          mul_cap_cyc = -1;
  logic [63:0] mul_prod;
  int          div_done_cyc = -1;
  logic [31:0] div_q_s;
  logic [31:0] div_r_s;

  // ---------------- driver: one clock cycle ----------------
  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input logic v, input logic [2:0] o, input logic [31:0] rs,
                       input logic [31:0] rt);
    logic   outstanding;
    logic   acc;
    logic   exp_mul;
    logic   exp_div;
    logic   [63:0] qr;
    state_t exp_state;

    bus.op_valid = v;
    bus.op       = o;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    bus.mul_z    = (cyc == mul_cap_cyc) ? mul_prod : {$urandom(), $urandom()};
    if (cyc == div_done_cyc) begin
      bus.div_done = 1'b1;
      bus.div_q    = div_q_s;
      bus.div_r    = div_r_s;
    end else begin
      bus.div_done = (div_done_cyc < cyc) && ($urandom_range(0, 7) == 0);
      bus.div_q    = $urandom();
      bus.div_r    = $urandom();
    end

    @(negedge clk);
    outstanding = (m_pend_end >= cyc);
    acc         = v && !outstanding;
    exp_mul     = acc && (o == MULTU || o == MULT);
    exp_div     = acc && (o == DIVU || o == DIV) && (rt != 32'd0);
    exp_state   = outstanding ? m_kind : IDLE;

    check("stall", bus.stall, v && outstanding);
    check("busy", busy, outstanding);
    check("state", dbg_state, exp_state);
    check("mul_ena", bus.mul_ena, exp_mul);
    check("div_start", bus.div_start, exp_div);
    if (exp_mul) check("mul_signed", bus.mul_signed, o[0]);
    if (exp_div) check("div_signed", bus.div_signed, o[0]);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    if (acc && (o == MFHI || o == MFLO)) begin
      exp_q.push_back((o == MFHI) ? m_hi : m_lo);
      check("rd_data", bus.rd_data, exp_q.pop_front());
    end else begin
      check("rd_zero", bus.rd_data, 32'd0);
    end

    // Stubs respond to what the DUT actually issued.
    if (bus.mul_ena) begin
      mul_cap_cyc = cyc + MUL_LAT;
      mul_prod    = mul_ref(rs, rt, bus.mul_signed);
    end
    if (bus.div_start) begin
      div_done_cyc = cyc + next_div_lat;
      qr           = div_ref(rs, rt, bus.div_signed);
      div_q_s      = qr[63:32];
      div_r_s      = qr[31:0];
    end

    // Model update for the closing edge.
    if (cyc == m_pend_end) begin
      m_hi = m_pend_hi;
      m_lo = m_pend_lo;
    end
    if (acc) begin
      case (o)
        MULTU, MULT: begin
          qr         = mul_ref(rs, rt, o[0]);
          m_pend_end = cyc + MUL_LAT;
          m_pend_hi  = qr[63:32];
          m_pend_lo  = qr[31:0];
          m_kind     = MUL_WAIT;
        end
        DIVU, DIV: begin
          if (rt != 32'd0) begin
            qr         = div_ref(rs, rt, o[0]);
            m_pend_end = cyc + next_div_lat;
            m_pend_hi  = qr[31:0];
            m_pend_lo  = qr[63:32];
            m_kind     = DIV_WAIT;
          end
        end
        MTHI:    m_hi = rs;
        MTLO:    m_lo = rs;
        default: ;
      endcase
    end

    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Present an op until it is taken (stall-aware re-presentation).
  task automatic issue(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt);
    int   tries;
    logic stalled;
    tries = 0;
    do begin
      stalled = (m_pend_end >= cyc);
      cycle(1'b1, o, rs, rt);
      tries++;
    end while (stalled && tries < 100);
    if (stalled) check("issue_timeout", 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, MFHI, 32'd0, 32'd0);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic do_reset_mid();
    #2;
    reset        = 1'b1;
    bus.op_valid = 1'b1;
    bus.op       = MFHI;
    bus.div_done = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rd", bus.rd_data, 32'd0);
    m_hi       = 32'd0;
    m_lo       = 32'd0;
    m_pend_end = -1;
    exp_q.delete();
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic       v;
    logic [2:0] o;
    logic [31:0] rs;
    logic [31:0] rt;

    reset          = 1'b1;
    bus.op_valid   = 1'b0;
    bus.op         = MULTU;
    bus.rs_val     = 32'd0;
    bus.rt_val     = 32'd0;
    bus.mul_z      = 64'd0;
    bus.div_done   = 1'b0;
    bus.div_q      = 32'd0;
    bus.div_r      = 32'd0;
    #1;
    check("por_hi", hi, 32'd0);
    check("por_lo", lo, 32'd0);
    check("por_busy", busy, 1'b0);
    check("por_stall", bus.stall, 1'b0);
    check("por_mul_ena", bus.mul_ena, 1'b0);
    check("por_div_start", bus.div_start, 1'b0);
    check("por_rd", bus.rd_data, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reads straight after reset.
    issue(MFHI, 32'd0, 32'd0);
    issue(MFLO, 32'd0, 32'd0);

    // Unsigned square of 0xFFFFFFFF; MFHI re-presented through the stall.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MFHI, 32'd0, 32'd0);
    issue(MFLO, 32'd0, 32'd0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // DIVU 17/3 with a 33-cycle divider.
    next_div_lat = 33;
    issue(DIVU, 32'd17, 32'd3);
    issue(MFLO, 32'd0, 32'd0);
    check("divu_lo", lo, 32'd5);
    check("divu_hi", hi, 32'd2);

    // Divide by zero leaves HI/LO alone and never stalls.
    issue(MTHI, 32'h1234, 32'd0);
    issue(MTLO, 32'h5678, 32'd0);
    issue(DIV, 32'd99, 32'd0);
    issue(DIVU, 32'd99, 32'd0);
    idle(2);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'h5678);

    // MTLO then MFLO back to back.
    issue(MTLO, 32'hA5A5_A5A5, 32'd0);
    issue(MFLO, 32'd0, 32'd0);
    // The same MTLO during MUL_WAIT is held off; LO takes the product.
    issue(MULT, 32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < MUL_LAT; i++) cycle(1'b1, MTLO, 32'hA5A5_A5A5, 32'd0);
    idle(1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // Signed divide, negative dividend.
    next_div_lat = 5;
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    idle(6);
    check("div_s_lo", lo, 32'hFFFF_FFFD);
    check("div_s_hi", hi, 32'hFFFF_FFFF);

    // Reset two cycles into DIV_WAIT; the divider's late done is ignored.
    next_div_lat = 20;
    issue(DIVU, 32'd100, 32'd7);
    idle(2);
    do_reset_mid();
    idle(25);
    check("late_done_hi", hi, 32'd0);
    check("late_done_lo", lo, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      next_div_lat = $urandom_range(1, 40);
      v  = ($urandom_range(0, 9) < 7);
      o  = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom();
      case ($urandom_range(0, 7))
        0:       rt = 32'd0;
        1:       rt = 32'hFFFF_FFFF;
        2:       rt = 32'($urandom_range(1, 20));
        default: rt = $urandom();
      endcase
      if ($urandom_range(0, 599) == 0) do_reset_mid();
      else cycle(v, o, rs, rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
